// File: rtl/register_writeback.sv
// rtl/register_writeback.sv - writeback stage: 2-entry result buffer draining into a 16x64 register file.
// Define WB_BYPASS_EN to forward the in-progress write onto registerFileOut in the same cycle.
module register_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbValidIn,
    input  logic [0:3]  destRegIn,
    input  logic        destRegValidIn,
    input  logic [63:0] destValIn,
    input  logic [0:3]  destRegisterSpecialIn,
    input  logic        destRegisterSpecialValidIn,
    input  logic [63:0] destValSpecialIn,
    input  logic [0:63] currentRipIn,
    output logic [63:0] registerFileOut [16],
    output logic        wbStallOut,
    output logic        wbBusyOut,
    output logic [0:63] lastRetiredRipOut,
    output logic [63:0] retireCountOut
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRIMARY = 2'd1;
    localparam logic [1:0] SPECIAL = 2'd2;

    logic [1:0]  state, stateNext;
    logic [63:0] regs [16];

    logic [0:3]  fifoDest       [2];
    logic        fifoDestValid  [2];
    logic [63:0] fifoVal        [2];
    logic [0:3]  fifoSpec       [2];
    logic        fifoSpecValid  [2];
    logic [63:0] fifoSpecVal    [2];
    logic [0:63] fifoRip        [2];

    logic        wrPtr, rdPtr;
    logic [1:0]  count, countNext;
    logic        push, pop;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [63:0] wrData;

    assign wbStallOut = (count == 2'd2);
    assign wbBusyOut  = (state != IDLE);
    // A full buffer refuses the push even if the head pops this same cycle.
    assign push       = wbValidIn && !wbStallOut;

    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + 2'd1;
            2'b01:   countNext = count - 2'd1;
            default: countNext = count;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        wrEn      = 1'b0;
        wrAddr    = 4'd0;
        wrData    = 64'd0;
        stateNext = state;
        case (state)
            IDLE: begin
                stateNext = push ? PRIMARY : IDLE;
            end
            PRIMARY: begin
                wrEn   = fifoDestValid[rdPtr];
                wrAddr = fifoDest[rdPtr];
                wrData = fifoVal[rdPtr];
                if (fifoSpecValid[rdPtr]) begin
                    stateNext = SPECIAL;
                end else begin
                    pop       = 1'b1;
                    stateNext = (countNext != 2'd0) ? PRIMARY : IDLE;
                end
            end
            SPECIAL: begin
                wrEn      = 1'b1;
                wrAddr    = fifoSpec[rdPtr];
                wrData    = fifoSpecVal[rdPtr];
                pop       = 1'b1;
                stateNext = (countNext != 2'd0) ? PRIMARY : IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Payload storage needs no reset; count and pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoDest[wrPtr]      <= destRegIn;
            fifoDestValid[wrPtr] <= destRegValidIn;
            fifoVal[wrPtr]       <= destValIn;
            fifoSpec[wrPtr]      <= destRegisterSpecialIn;
            fifoSpecValid[wrPtr] <= destRegisterSpecialValidIn;
            fifoSpecVal[wrPtr]   <= destValSpecialIn;
            fifoRip[wrPtr]       <= currentRipIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            count             <= 2'd0;
            wrPtr             <= 1'b0;
            rdPtr             <= 1'b0;
            lastRetiredRipOut <= '0;
            retireCountOut    <= 64'd0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 64'd0;
            end
        end else begin
            state <= stateNext;
            count <= countNext;
            if (push) begin
                wrPtr <= ~wrPtr;
            end
            if (pop) begin
                rdPtr             <= ~rdPtr;
                lastRetiredRipOut <= fifoRip[rdPtr];
                retireCountOut    <= retireCountOut + 64'd1;
            end
            if (wrEn) begin
                regs[wrAddr] <= wrData;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            registerFileOut[i] = regs[i];
`ifdef WB_BYPASS_EN
            if (wrEn && (wrAddr == 4'(i))) begin
                registerFileOut[i] = wrData;
            end
`endif
        end
    end
endmodule

// File: tb/tb_register_writeback.sv
// tb/tb_register_writeback.sv - self-checking bench for register_writeback with a retire scoreboard.
module tb_register_writeback;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [63:0] rip;
        logic [3:0]  dr;
        logic        dv;
        logic [63:0] dval;
        logic [3:0]  sr;
        logic        sv;
        logic [63:0] sval;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbValidIn;
    logic [0:3]  destRegIn;
    logic        destRegValidIn;
    logic [63:0] destValIn;
    logic [0:3]  destRegisterSpecialIn;
    logic        destRegisterSpecialValidIn;
    logic [63:0] destValSpecialIn;
    logic [0:63] currentRipIn;
    logic [63:0] registerFileOut [16];
    logic        wbStallOut;
    logic        wbBusyOut;
    logic [0:63] lastRetiredRipOut;
    logic [63:0] retireCountOut;

    int          compared = 0;
    int          mismatched = 0;
    logic [63:0] expRetire = 64'd0;
    ent_t        sb[$];

    always #5 clk = ~clk;

    register_writeback dut (
        .clk                        (clk),
        .reset                      (reset),
        .wbValidIn                  (wbValidIn),
        .destRegIn                  (destRegIn),
        .destRegValidIn             (destRegValidIn),
        .destValIn                  (destValIn),
        .destRegisterSpecialIn      (destRegisterSpecialIn),
        .destRegisterSpecialValidIn (destRegisterSpecialValidIn),
        .destValSpecialIn           (destValSpecialIn),
        .currentRipIn               (currentRipIn),
        .registerFileOut            (registerFileOut),
        .wbStallOut                 (wbStallOut),
        .wbBusyOut                  (wbBusyOut),
        .lastRetiredRipOut          (lastRetiredRipOut),
        .retireCountOut             (retireCountOut)
    );

    task automatic clear_inputs();
        wbValidIn                  = 1'b0;
        destRegIn                  = 4'd0;
        destRegValidIn             = 1'b0;
        destValIn                  = 64'd0;
        destRegisterSpecialIn      = 4'd0;
        destRegisterSpecialValidIn = 1'b0;
        destValSpecialIn           = 64'd0;
        currentRipIn               = 64'd0;
    endtask

    task automatic drive(input ent_t e);
        wbValidIn                  = 1'b1;
        destRegIn                  = e.dr;
        destRegValidIn             = e.dv;
        destValIn                  = e.dval;
        destRegisterSpecialIn      = e.sr;
        destRegisterSpecialValidIn = e.sv;
        destValSpecialIn           = e.sval;
        currentRipIn               = e.rip;
    endtask

    function automatic ent_t mk(input logic [63:0] rip, input logic [3:0] dr, input logic dv,
                                input logic [63:0] dval, input logic [3:0] sr, input logic sv,
                                input logic [63:0] sval);
        ent_t e;
        e.rip = rip; e.dr = dr; e.dv = dv; e.dval = dval;
        e.sr = sr; e.sv = sv; e.sval = sval;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            compared++;
            if (registerFileOut[i] !== 64'd0) begin
                mismatched++;
                $display("FAIL reset_reg%0d got %h want 0", i, registerFileOut[i]);
            end
        end
        compared++;
        if ({wbStallOut, wbBusyOut} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_flags stall/busy got %b want 00", {wbStallOut, wbBusyOut});
        end
        compared++;
        if (retireCountOut !== 64'd0 || lastRetiredRipOut !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_retire count %0d rip %h want 0/0", retireCountOut, lastRetiredRipOut);
        end
    endtask

    task automatic test_single_write();
        drive(mk(64'h1000, 4'd3, 1'b1, 64'hDEADBEEF_00000001, 4'd0, 1'b0, 64'd0));
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        compared++;
        if (registerFileOut[3] !== (BYP ? 64'hDEADBEEF_00000001 : 64'd0)) begin
            mismatched++;
            $display("FAIL single_before got %h want %h", registerFileOut[3],
                     BYP ? 64'hDEADBEEF_00000001 : 64'd0);
        end
        compared++;
        if (wbBusyOut !== 1'b1) begin
            mismatched++;
            $display("FAIL single_busy got %b want 1", wbBusyOut);
        end
        @(negedge clk);
        expRetire = expRetire + 64'd1;
        compared++;
        if (registerFileOut[3] !== 64'hDEADBEEF_00000001) begin
            mismatched++;
            $display("FAIL single_reg3 got %h want deadbeef00000001", registerFileOut[3]);
        end
        compared++;
        if (retireCountOut !== expRetire || lastRetiredRipOut !== 64'h1000) begin
            mismatched++;
            $display("FAIL single_retire count %0d rip %h want %0d/1000", retireCountOut,
                     lastRetiredRipOut, expRetire);
        end
        compared++;
        if (wbBusyOut !== 1'b0) begin
            mismatched++;
            $display("FAIL single_idle busy got %b want 0", wbBusyOut);
        end
    endtask

    task automatic test_bypass();
        drive(mk(64'h1100, 4'd7, 1'b1, 64'h55, 4'd0, 1'b0, 64'd0));
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        compared++;
        if (registerFileOut[7] !== (BYP ? 64'h55 : 64'd0) || registerFileOut[6] !== 64'd0) begin
            mismatched++;
            $display("FAIL bypass_during reg7 %h reg6 %h want %h/0", registerFileOut[7],
                     registerFileOut[6], BYP ? 64'h55 : 64'd0);
        end
        @(negedge clk);
        expRetire = expRetire + 64'd1;
        compared++;
        if (registerFileOut[7] !== 64'h55) begin
            mismatched++;
            $display("FAIL bypass_after reg7 got %h want 55", registerFileOut[7]);
        end
    endtask

    task automatic test_imul();
        drive(mk(64'h2000, 4'd0, 1'b1, 64'h10, 4'd2, 1'b1, 64'h20));
        @(posedge clk);
        @(negedge clk);
        drive(mk(64'h2004, 4'd1, 1'b1, 64'h30, 4'd0, 1'b0, 64'd0));
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        compared++;
        if (registerFileOut[0] !== 64'h10 || registerFileOut[2] !== (BYP ? 64'h20 : 64'd0)) begin
            mismatched++;
            $display("FAIL imul_n1 rax %h rdx %h want 10/%h", registerFileOut[0],
                     registerFileOut[2], BYP ? 64'h20 : 64'd0);
        end
        compared++;
        if (retireCountOut !== expRetire || wbStallOut !== 1'b1) begin
            mismatched++;
            $display("FAIL imul_n1_state count %0d stall %b want %0d/1", retireCountOut,
                     wbStallOut, expRetire);
        end
        @(negedge clk);
        expRetire = expRetire + 64'd1;
        compared++;
        if (registerFileOut[2] !== 64'h20 || retireCountOut !== expRetire ||
            lastRetiredRipOut !== 64'h2000) begin
            mismatched++;
            $display("FAIL imul_n2 rdx %h count %0d rip %h want 20/%0d/2000", registerFileOut[2],
                     retireCountOut, lastRetiredRipOut, expRetire);
        end
        compared++;
        if (registerFileOut[1] !== (BYP ? 64'h30 : 64'd0) || wbStallOut !== 1'b0) begin
            mismatched++;
            $display("FAIL imul_second_wait reg1 %h stall %b want %h/0", registerFileOut[1],
                     wbStallOut, BYP ? 64'h30 : 64'd0);
        end
        @(negedge clk);
        expRetire = expRetire + 64'd1;
        compared++;
        if (registerFileOut[1] !== 64'h30 || retireCountOut !== expRetire ||
            lastRetiredRipOut !== 64'h2004 || wbBusyOut !== 1'b0) begin
            mismatched++;
            $display("FAIL imul_second reg1 %h count %0d rip %h busy %b want 30/%0d/2004/0",
                     registerFileOut[1], retireCountOut, lastRetiredRipOut, wbBusyOut, expRetire);
        end
    endtask

    task automatic test_same_reg();
        drive(mk(64'h3000, 4'd5, 1'b1, 64'h1, 4'd5, 1'b1, 64'h2));
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        compared++;
        if (registerFileOut[5] !== (BYP ? 64'h2 : 64'h1)) begin
            mismatched++;
            $display("FAIL same_reg_mid got %h want %h", registerFileOut[5], BYP ? 64'h2 : 64'h1);
        end
        @(negedge clk);
        expRetire = expRetire + 64'd1;
        compared++;
        if (registerFileOut[5] !== 64'h2 || retireCountOut !== expRetire) begin
            mismatched++;
            $display("FAIL same_reg_final reg5 %h count %0d want 2/%0d", registerFileOut[5],
                     retireCountOut, expRetire);
        end
    endtask

    task automatic test_back_to_back();
        ent_t        pend[$];
        ent_t        e;
        int          cycles = 0;
        int          stalls = 0;
        logic        acc;
        logic [63:0] prev;
        for (int k = 0; k < 8; k++) begin
            pend.push_back(mk(64'h4000 + 64'(k * 4), 4'(k * 2), (k % 4) != 3,
                              {$urandom, $urandom}, 4'(k * 2 + 1), 1'b0, 64'd0));
        end
        prev = retireCountOut;
        while ((pend.size() > 0 || sb.size() > 0) && cycles < 100) begin
            if (pend.size() > 0) drive(pend[0]);
            else clear_inputs();
            if (wbStallOut) stalls++;
            acc = (pend.size() > 0) && !wbStallOut;
            @(posedge clk);
            if (acc) sb.push_back(pend.pop_front());
            @(negedge clk);
            cycles++;
            if (retireCountOut !== prev) begin
                expRetire = expRetire + 64'd1;
                prev = retireCountOut;
                compared++;
                if (sb.size() == 0 || retireCountOut !== expRetire) begin
                    mismatched++;
                    $display("FAIL b2b_retire count %0d want %0d pending %0d", retireCountOut,
                             expRetire, sb.size());
                end else begin
                    e = sb.pop_front();
                    compared++;
                    if (lastRetiredRipOut !== e.rip ||
                        (e.dv && registerFileOut[e.dr] !== e.dval)) begin
                        mismatched++;
                        $display("FAIL b2b_entry rip %h reg%0d %h want %h/%h", lastRetiredRipOut,
                                 e.dr, registerFileOut[e.dr], e.rip, e.dval);
                    end
                end
            end
        end
        clear_inputs();
        compared++;
        if (cycles != 9 || stalls != 0 || pend.size() != 0 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_throughput cycles %0d stalls %0d left %0d want 9/0/0", cycles,
                     stalls, pend.size() + sb.size());
        end
    endtask

    task automatic test_backpressure();
        ent_t        pend[$];
        ent_t        e;
        int          cycles = 0;
        logic        acc;
        logic [63:0] prev;
        logic [63:0] start;
        for (int k = 0; k < 3; k++) begin
            pend.push_back(mk(64'h5000 + 64'(k * 8), 4'(k * 2 + 8), 1'b1, {$urandom, $urandom},
                              4'(k * 2 + 9), 1'b1, {$urandom, $urandom}));
        end
        prev  = retireCountOut;
        start = retireCountOut;
        while ((pend.size() > 0 || sb.size() > 0) && cycles < 100) begin
            if (pend.size() > 0) drive(pend[0]);
            else clear_inputs();
            acc = (pend.size() > 0) && !wbStallOut;
            @(posedge clk);
            if (acc) sb.push_back(pend.pop_front());
            @(negedge clk);
            cycles++;
            if (cycles == 2 || cycles == 3) begin
                compared++;
                if (wbStallOut !== (cycles == 2)) begin
                    mismatched++;
                    $display("FAIL bp_stall cycle %0d got %b want %b", cycles, wbStallOut,
                             cycles == 2);
                end
            end
            if (retireCountOut !== prev) begin
                expRetire = expRetire + 64'd1;
                prev = retireCountOut;
                compared++;
                if (sb.size() == 0 || retireCountOut !== expRetire) begin
                    mismatched++;
                    $display("FAIL bp_retire count %0d want %0d pending %0d", retireCountOut,
                             expRetire, sb.size());
                end else begin
                    e = sb.pop_front();
                    compared++;
                    if (lastRetiredRipOut !== e.rip || registerFileOut[e.dr] !== e.dval ||
                        registerFileOut[e.sr] !== e.sval) begin
                        mismatched++;
                        $display("FAIL bp_entry rip %h p %h s %h want %h/%h/%h", lastRetiredRipOut,
                                 registerFileOut[e.dr], registerFileOut[e.sr], e.rip, e.dval,
                                 e.sval);
                    end
                end
            end
        end
        clear_inputs();
        compared++;
        if (cycles != 7 || retireCountOut !== start + 64'd3 || pend.size() != 0 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL bp_total cycles %0d retired %0d left %0d want 7/3/0", cycles,
                     retireCountOut - start, pend.size() + sb.size());
        end
    endtask

    task automatic test_reset_mid_special();
        drive(mk(64'h6000, 4'd9, 1'b1, 64'h99, 4'd10, 1'b1, 64'hAA));
        @(posedge clk);
        @(negedge clk);
        drive(mk(64'h6004, 4'd11, 1'b1, 64'hBB, 4'd0, 1'b0, 64'd0));
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        compared++;
        if (registerFileOut[9] !== 64'h99 || wbBusyOut !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_preload reg9 %h busy %b want 99/1", registerFileOut[9], wbBusyOut);
        end
        reset = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            compared++;
            if (registerFileOut[i] !== 64'd0) begin
                mismatched++;
                $display("FAIL rst_mid_reg%0d got %h want 0", i, registerFileOut[i]);
            end
        end
        compared++;
        if (retireCountOut !== 64'd0 || lastRetiredRipOut !== 64'd0 ||
            wbStallOut !== 1'b0 || wbBusyOut !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_state count %0d rip %h stall %b busy %b want 0/0/0/0",
                     retireCountOut, lastRetiredRipOut, wbStallOut, wbBusyOut);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (registerFileOut[10] !== 64'd0 || registerFileOut[11] !== 64'd0 ||
            retireCountOut !== 64'd0 || wbBusyOut !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_discard r10 %h r11 %h count %0d busy %b want 0/0/0/0",
                     registerFileOut[10], registerFileOut[11], retireCountOut, wbBusyOut);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_bypass();
        test_imul();
        test_same_reg();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_special();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
